// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, optional 2-entry skid buffer
// and flush-to-bubble. Control and data fields travel together in one payload bus.
module pipe_stage_reg #(
  parameter int unsigned       DATA_W  = 32,
  parameter logic [DATA_W-1:0] NOP_VAL = '0,
  parameter bit                SKID    = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              out_valid_q, out_valid_d;
  logic [1:0]        occ_q, occ_d;
  logic              in_ready_q;
  logic              in_fire, out_fire;

  // With a skid buffer in_ready comes straight from a flop, so no ready path
  // crosses the stage; without it the stage can accept only when it drains.
  assign in_ready  = SKID ? in_ready_q : (out_ready | ~out_valid_q);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid_q & out_ready;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign occupancy = occ_q;

  always_comb begin
    // NOTE: every next-state variable gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    unique case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d = ST_ONE;
          main_d  = in_data;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire) begin
          if (SKID) begin
            state_d = ST_FULL;
            skid_d  = in_data;
          end
        end else if (out_fire) begin
          state_d = ST_EMPTY;
          main_d  = NOP_VAL;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          state_d = ST_ONE;
          main_d  = skid_q;
          skid_d  = NOP_VAL;
        end
      end
      default: begin
        state_d = ST_EMPTY;
        main_d  = NOP_VAL;
        skid_d  = NOP_VAL;
      end
    endcase

    // Flush overrides everything; handshakes still complete but payloads are dropped.
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = NOP_VAL;
      skid_d  = NOP_VAL;
    end

    out_valid_d = (state_d != ST_EMPTY);
    unique case (state_d)
      ST_ONE:  occ_d = 2'd1;
      ST_FULL: occ_d = 2'd2;
      default: occ_d = 2'd0;
    endcase
  end

  // NOTE: the payload registers are reset too, because out_data must read as
  // NOP_VAL from the moment reset asserts, not merely after the first clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_EMPTY;
      main_q      <= NOP_VAL;
      skid_q      <= NOP_VAL;
      out_valid_q <= 1'b0;
      occ_q       <= 2'd0;
      in_ready_q  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      occ_q       <= occ_d;
      in_ready_q  <= (state_d != ST_FULL);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and scoreboard-checked bench for pipe_stage_reg, with and without skid buffer.
module tb_pipe_stage_reg;

  localparam int unsigned DW  = 32;
  localparam logic [DW-1:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          reset_n;

  logic          s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_flush;
  logic [DW-1:0] s_in_data, s_out_data;
  logic [1:0]    s_occ;

  logic          p_in_valid, p_in_ready, p_out_valid, p_out_ready, p_flush;
  logic [DW-1:0] p_in_data, p_out_data;
  logic [1:0]    p_occ;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .NOP_VAL(NOP), .SKID(1'b1)) u_dut_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .in_data   (s_in_data),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .out_data  (s_out_data),
    .flush     (s_flush),
    .occupancy (s_occ)
  );

  pipe_stage_reg #(.DATA_W(DW), .NOP_VAL(NOP), .SKID(1'b0)) u_dut_plain (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (p_in_valid),
    .in_ready  (p_in_ready),
    .in_data   (p_in_data),
    .out_valid (p_out_valid),
    .out_ready (p_out_ready),
    .out_data  (p_out_data),
    .flush     (p_flush),
    .occupancy (p_occ)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic s_drive(input logic v, input logic [DW-1:0] d, input logic rdy, input logic fl);
    s_in_valid  = v;
    s_in_data   = d;
    s_out_ready = rdy;
    s_flush     = fl;
  endtask

  task automatic s_expect(input string tag, input logic ov, input logic [DW-1:0] od,
                          input logic [1:0] occ, input logic ir);
    check({tag, "_valid"}, DW'(s_out_valid), DW'(ov));
    check({tag, "_data"},  s_out_data,       od);
    check({tag, "_occ"},   DW'(s_occ),       DW'(occ));
    check({tag, "_ready"}, DW'(s_in_ready),  DW'(ir));
  endtask

  logic [DW-1:0] sb_q[$];
  logic          exp_in_fire, exp_out_fire;

  initial begin
    reset_n = 1'b0;
    s_drive(1'b0, '0, 1'b0, 1'b0);
    p_in_valid = 1'b0; p_in_data = '0; p_out_ready = 1'b0; p_flush = 1'b0;
    #12;
    s_expect("reset", 1'b0, NOP, 2'd0, 1'b1);
    check("reset_plain_valid", DW'(p_out_valid), 32'd0);
    check("reset_plain_data", p_out_data, NOP);
    @(negedge clk);
    reset_n = 1'b1;

    // Streaming 1..8 with downstream always ready.
    for (int i = 1; i <= 8; i++) begin
      s_drive(1'b1, DW'(i), 1'b1, 1'b0);
      check("stream_in_ready", DW'(s_in_ready), 32'd1);
      tick();
      check("stream_valid", DW'(s_out_valid), 32'd1);
      check("stream_data", s_out_data, DW'(i));
      check("stream_occ", DW'(s_occ), 32'd1);
    end
    s_drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    s_expect("stream_drain", 1'b0, NOP, 2'd0, 1'b1);

    // Back-pressure into the skid entry, then drain in order.
    s_drive(1'b1, 32'h11, 1'b0, 1'b0);
    tick();
    s_expect("bp_one", 1'b1, 32'h11, 2'd1, 1'b1);
    s_drive(1'b1, 32'h22, 1'b0, 1'b0);
    tick();
    s_expect("bp_full", 1'b1, 32'h11, 2'd2, 1'b0);
    s_drive(1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    tick();
    s_expect("bp_stall", 1'b1, 32'h11, 2'd2, 1'b0);
    s_drive(1'b0, '0, 1'b1, 1'b0);
    #1;
    check("bp_head_before_pop", s_out_data, 32'h11);
    tick();
    s_expect("bp_second", 1'b1, 32'h22, 2'd1, 1'b1);
    tick();
    s_expect("bp_empty", 1'b0, NOP, 2'd0, 1'b1);

    // Flush while FULL with a payload offered on the input.
    s_drive(1'b1, 32'h44, 1'b0, 1'b0);
    tick();
    s_drive(1'b1, 32'h55, 1'b0, 1'b0);
    tick();
    s_expect("fl_full", 1'b1, 32'h44, 2'd2, 1'b0);
    s_drive(1'b1, 32'h33, 1'b0, 1'b1);
    tick();
    s_drive(1'b0, '0, 1'b1, 1'b0);
    s_expect("fl_after", 1'b0, NOP, 2'd0, 1'b1);
    tick();
    s_expect("fl_after2", 1'b0, NOP, 2'd0, 1'b1);

    // Flush in ONE while an input handshake completes: payload is discarded.
    s_drive(1'b1, 32'h66, 1'b0, 1'b0);
    tick();
    s_drive(1'b1, 32'h33, 1'b0, 1'b1);
    #1;
    check("fl_one_in_ready", DW'(s_in_ready), 32'd1);
    tick();
    s_drive(1'b0, '0, 1'b0, 1'b0);
    s_expect("fl_one_after", 1'b0, NOP, 2'd0, 1'b1);

    // Asynchronous reset while FULL.
    s_drive(1'b1, 32'hA5A5_0001, 1'b0, 1'b0);
    tick();
    s_drive(1'b1, 32'hA5A5_0002, 1'b0, 1'b0);
    tick();
    s_expect("ar_full", 1'b1, 32'hA5A5_0001, 2'd2, 1'b0);
    s_drive(1'b0, '0, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    s_expect("ar_async", 1'b0, NOP, 2'd0, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;

    // Single-register variant: combinational ready, replace in place.
    p_in_valid = 1'b1; p_in_data = 32'h77; p_out_ready = 1'b0;
    #1;
    check("p_empty_ready", DW'(p_in_ready), 32'd1);
    tick();
    check("p_one_data", p_out_data, 32'h77);
    check("p_one_occ", DW'(p_occ), 32'd1);
    check("p_stall_ready", DW'(p_in_ready), 32'd0);
    tick();
    check("p_stall_data", p_out_data, 32'h77);
    p_out_ready = 1'b1; p_in_data = 32'h88;
    #1;
    check("p_drain_ready", DW'(p_in_ready), 32'd1);
    tick();
    check("p_replace_valid", DW'(p_out_valid), 32'd1);
    check("p_replace_data", p_out_data, 32'h88);
    check("p_replace_occ", DW'(p_occ), 32'd1);
    p_in_valid = 1'b0;
    tick();
    check("p_drain_valid", DW'(p_out_valid), 32'd0);
    check("p_drain_data", p_out_data, NOP);

    // Random traffic on the skid instance against a FIFO scoreboard.
    for (int c = 0; c < 400; c++) begin
      s_drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 15) == 0));
      #1;
      exp_in_fire  = s_in_valid & s_in_ready;
      exp_out_fire = s_out_valid & s_out_ready;
      if (exp_out_fire) begin
        if (sb_q.size() == 0) check("sb_underflow", DW'(s_out_valid), 32'd0);
        else check("sb_data", s_out_data, sb_q.pop_front());
      end
      if (exp_in_fire) sb_q.push_back(s_in_data);
      if (s_flush) sb_q.delete();
      tick();
      check("sb_occ", DW'(s_occ), DW'(sb_q.size()));
      check("sb_valid", DW'(s_out_valid), DW'(sb_q.size() != 0));
      check("sb_ready", DW'(s_in_ready), DW'(sb_q.size() < 2));
      if (sb_q.size() == 0) check("sb_bubble", s_out_data, NOP);
      else check("sb_head", s_out_data, sb_q[0]);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
